// File: rtl/edit_time_fields_if.sv
// Front-panel time-edit bus: button ticks and RTC time in, edited time, cursor and commit strobe out.
// master drives ticks and current time; slave is the editor.
interface edit_time_fields_if;
   logic       tick_enter;
   logic       tick_up;
   logic       tick_down;
   logic       tick_left;
   logic       tick_right;
   logic [7:0] hh_in;
   logic [7:0] mm_in;
   logic [7:0] ss_in;
   logic [7:0] hh_out;
   logic [7:0] mm_out;
   logic [7:0] ss_out;
   logic [1:0] cursor;
   logic       editing;
   logic       wr_strobe;

   modport master (
      output tick_enter, tick_up, tick_down, tick_left, tick_right,
      output hh_in, mm_in, ss_in,
      input  hh_out, mm_out, ss_out, cursor, editing, wr_strobe
   );

   modport slave (
      input  tick_enter, tick_up, tick_down, tick_left, tick_right,
      input  hh_in, mm_in, ss_in,
      output hh_out, mm_out, ss_out, cursor, editing, wr_strobe
   );
endinterface

// File: rtl/edit_time_fields.sv
// Button-driven BCD hh:mm:ss editor with IDLE/EDIT/COMMIT FSM; each tick acts on the next clkr edge,
// wr_strobe pulses one cycle after the closing enter. No backpressure: ticks are single-cycle and never queued.
module edit_time_fields #(
   parameter int HOUR_MAX       = 23,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic              clkr,
   input  logic              resetr,
   edit_time_fields_if.slave tif
);

   localparam int              CW           = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0]   CNT_LAST     = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]      HOUR_MAX_BCD = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};
   localparam logic [7:0]      MS_MAX_BCD   = 8'h59;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EDIT   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t        state_q;
   logic [7:0]    hh_q;
   logic [7:0]    mm_q;
   logic [7:0]    ss_q;
   logic [1:0]    cursor_q;
   logic          editing_q;
   logic          wr_strobe_q;
   logic [CW-1:0] cnt_q;

   logic [7:0]    sel_val;
   logic [7:0]    sel_max;
   logic [7:0]    inc_val;
   logic [7:0]    dec_val;
   logic          any_tick;

   // A field is kept only if both digits are decimal and it does not exceed its maximum.
   function automatic logic [7:0] sanitize(input logic [7:0] v, input logic [7:0] vmax);
      logic [7:0] r;
      r = v;
      if ((v[7:4] > 4'd9) || (v[3:0] > 4'd9) || (v > vmax)) begin
         r = 8'h00;
      end
      return r;
   endfunction

   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
      logic [7:0] r;
      if (v == vmax) begin
         r = 8'h00;
      end else if (v[3:0] == 4'd9) begin
         r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] vmax);
      logic [7:0] r;
      if (v == 8'h00) begin
         r = vmax;
      end else if (v[3:0] == 4'd0) begin
         r = {v[7:4] - 4'd1, 4'd9};
      end else begin
         r = {v[7:4], v[3:0] - 4'd1};
      end
      return r;
   endfunction

   always_comb begin
      sel_val = 8'h00;
      sel_max = MS_MAX_BCD;
      case (cursor_q)
         2'd0: begin
            sel_val = hh_q;
            sel_max = HOUR_MAX_BCD;
         end
         2'd1:    sel_val = mm_q;
         2'd2:    sel_val = ss_q;
         default: sel_val = 8'h00;
      endcase
   end

   assign inc_val  = bcd_inc(sel_val, sel_max);
   assign dec_val  = bcd_dec(sel_val, sel_max);
   assign any_tick = tif.tick_enter | tif.tick_up | tif.tick_down | tif.tick_left | tif.tick_right;

   always_ff @(posedge clkr) begin
      if (resetr) begin
         state_q     <= IDLE;
         hh_q        <= 8'h00;
         mm_q        <= 8'h00;
         ss_q        <= 8'h00;
         cursor_q    <= 2'd0;
         editing_q   <= 1'b0;
         wr_strobe_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               wr_strobe_q <= 1'b0;
               if (tif.tick_enter) begin
                  hh_q      <= sanitize(tif.hh_in, HOUR_MAX_BCD);
                  mm_q      <= sanitize(tif.mm_in, MS_MAX_BCD);
                  ss_q      <= sanitize(tif.ss_in, MS_MAX_BCD);
                  cursor_q  <= 2'd0;
                  cnt_q     <= '0;
                  editing_q <= 1'b1;
                  state_q   <= EDIT;
               end
            end

            EDIT: begin
               if (any_tick) begin
                  cnt_q <= '0;
                  // Single action per cycle; lower-priority ticks in the same cycle are dropped.
                  if (tif.tick_enter) begin
                     editing_q   <= 1'b0;
                     wr_strobe_q <= 1'b1;
                     state_q     <= COMMIT;
                  end else if (tif.tick_up || tif.tick_down) begin
                     case (cursor_q)
                        2'd0:    hh_q <= tif.tick_up ? inc_val : dec_val;
                        2'd1:    mm_q <= tif.tick_up ? inc_val : dec_val;
                        2'd2:    ss_q <= tif.tick_up ? inc_val : dec_val;
                        default: ;
                     endcase
                  end else if (tif.tick_left) begin
                     cursor_q <= (cursor_q == 2'd0) ? 2'd2 : cursor_q - 2'd1;
                  end else begin
                     cursor_q <= (cursor_q == 2'd2) ? 2'd0 : cursor_q + 2'd1;
                  end
               end else if (cnt_q == CNT_LAST) begin
                  editing_q <= 1'b0;
                  state_q   <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            COMMIT: begin
               wr_strobe_q <= 1'b0;
               state_q     <= IDLE;
            end

            default: begin
               editing_q   <= 1'b0;
               wr_strobe_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase

         // Cursor 3 cannot be reached legitimately; recover on the next edge.
         if (cursor_q == 2'd3) begin
            cursor_q <= 2'd0;
         end
      end
   end

   assign tif.hh_out    = hh_q;
   assign tif.mm_out    = mm_q;
   assign tif.ss_out    = ss_q;
   assign tif.cursor    = cursor_q;
   assign tif.editing   = editing_q;
   assign tif.wr_strobe = wr_strobe_q;

endmodule

// File: tb/tb_edit_time_fields.sv
// Directed scenarios plus random ticks for edit_time_fields, compared each cycle against a decimal-integer model.
module tb_edit_time_fields;
   localparam int HMAX = 23;
   localparam int TOUT = 8;

   logic clkr = 1'b0;
   logic resetr;

   edit_time_fields_if tif();

   edit_time_fields #(
      .HOUR_MAX       (HMAX),
      .TIMEOUT_CYCLES (TOUT)
   ) dut (
      .clkr   (clkr),
      .resetr (resetr),
      .tif    (tif)
   );

   always #5 clkr = ~clkr;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: mode 0 idle, 1 edit, 2 commit; fields held as plain decimal integers.
   int m_mode = 0;
   int m_cur  = 0;
   int m_idle = 0;
   int m_f[3] = '{0, 0, 0};
   int fmax[3] = '{HMAX, 59, 59};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic int from_bcd(input logic [7:0] b, input int mx);
      int hi, lo, v;
      hi = int'(b[7:4]);
      lo = int'(b[3:0]);
      if (hi > 9 || lo > 9) return 0;
      v = hi * 10 + lo;
      return (v > mx) ? 0 : v;
   endfunction

   task automatic model_edge();
      if (resetr) begin
         m_mode = 0; m_cur = 0; m_idle = 0;
         for (int i = 0; i < 3; i++) m_f[i] = 0;
      end else begin
         case (m_mode)
            0: if (tif.tick_enter) begin
               m_f[0] = from_bcd(tif.hh_in, fmax[0]);
               m_f[1] = from_bcd(tif.mm_in, fmax[1]);
               m_f[2] = from_bcd(tif.ss_in, fmax[2]);
               m_cur  = 0;
               m_idle = 0;
               m_mode = 1;
            end
            1: begin
               if (tif.tick_enter) begin
                  m_mode = 2;
               end else if (tif.tick_up) begin
                  m_f[m_cur] = (m_f[m_cur] == fmax[m_cur]) ? 0 : m_f[m_cur] + 1;
                  m_idle = 0;
               end else if (tif.tick_down) begin
                  m_f[m_cur] = (m_f[m_cur] == 0) ? fmax[m_cur] : m_f[m_cur] - 1;
                  m_idle = 0;
               end else if (tif.tick_left) begin
                  m_cur = (m_cur + 2) % 3;
                  m_idle = 0;
               end else if (tif.tick_right) begin
                  m_cur = (m_cur + 1) % 3;
                  m_idle = 0;
               end else if (m_idle == TOUT - 1) begin
                  m_mode = 0;
               end else begin
                  m_idle++;
               end
            end
            default: m_mode = 0;
         endcase
      end
   endtask

   task automatic compare_all(input string pfx);
      chk({pfx, "_hh"},  32'(tif.hh_out),    32'(to_bcd(m_f[0])));
      chk({pfx, "_mm"},  32'(tif.mm_out),    32'(to_bcd(m_f[1])));
      chk({pfx, "_ss"},  32'(tif.ss_out),    32'(to_bcd(m_f[2])));
      chk({pfx, "_cur"}, 32'(tif.cursor),    32'(m_cur));
      chk({pfx, "_ed"},  32'(tif.editing),   32'(m_mode == 1));
      chk({pfx, "_wr"},  32'(tif.wr_strobe), 32'(m_mode == 2));
   endtask

   task automatic step(input bit rst, input bit e, input bit u, input bit d, input bit l, input bit r);
      resetr         = rst;
      tif.tick_enter = e;
      tif.tick_up    = u;
      tif.tick_down  = d;
      tif.tick_left  = l;
      tif.tick_right = r;
      @(posedge clkr);
      model_edge();
      @(negedge clkr);
      compare_all("cyc");
      resetr         = 1'b0;
      tif.tick_enter = 1'b0;
      tif.tick_up    = 1'b0;
      tif.tick_down  = 1'b0;
      tif.tick_left  = 1'b0;
      tif.tick_right = 1'b0;
   endtask

   task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      tif.hh_in = h;
      tif.mm_in = m;
      tif.ss_in = s;
   endtask

   function automatic logic [7:0] rand_field(input int mx);
      if ($urandom_range(0, 3) == 0) return 8'($urandom);
      return to_bcd(int'($urandom_range(0, mx)));
   endfunction

   initial begin
      resetr = 1'b1;
      tif.tick_enter = 1'b0; tif.tick_up = 1'b0; tif.tick_down = 1'b0;
      tif.tick_left  = 1'b0; tif.tick_right = 1'b0;
      set_time(8'h00, 8'h00, 8'h00);
      @(negedge clkr);

      // Reset state
      set_time(8'h12, 8'h34, 8'h56);
      step(1, 1, 1, 0, 0, 0);
      chk("rst_hh", 32'(tif.hh_out), 'h0);
      chk("rst_ed", 32'(tif.editing), 'h0);
      chk("rst_wr", 32'(tif.wr_strobe), 'h0);

      // Basic edit and commit
      set_time(8'h09, 8'h30, 8'h15);
      step(0, 1, 0, 0, 0, 0);
      chk("basic_ed", 32'(tif.editing), 'h1);
      chk("basic_mm", 32'(tif.mm_out), 'h30);
      step(0, 0, 1, 0, 0, 0);
      chk("basic_hh", 32'(tif.hh_out), 'h10);
      step(0, 1, 0, 0, 0, 0);
      chk("basic_wr", 32'(tif.wr_strobe), 'h1);
      step(0, 0, 0, 0, 0, 0);
      chk("basic_wr_off", 32'(tif.wr_strobe), 'h0);
      chk("basic_idle", 32'(tif.editing), 'h0);
      step(0, 0, 1, 0, 0, 0);
      chk("idle_hold_hh", 32'(tif.hh_out), 'h10);

      // Wrap cases
      set_time(8'h00, 8'h59, 8'h00);
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      chk("wrap_hh", 32'(tif.hh_out), 'h23);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 1, 0, 0, 0);
      chk("wrap_mm", 32'(tif.mm_out), 'h00);
      chk("wrap_mm_nocarry", 32'(tif.hh_out), 'h23);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 0, 0);
      chk("wrap_ss", 32'(tif.ss_out), 'h59);
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Cursor movement and tick priority
      set_time(8'h12, 8'h34, 8'h56);
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      chk("cur_left", 32'(tif.cursor), 'h2);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
      chk("cur_right3", 32'(tif.cursor), 'h2);
      step(0, 0, 1, 0, 1, 0);
      chk("prio_ss", 32'(tif.ss_out), 'h57);
      chk("prio_cur", 32'(tif.cursor), 'h2);
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Timeout abandons edit, keeps values
      set_time(8'h05, 8'h06, 8'h07);
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < TOUT - 1; i++) step(0, 0, 0, 0, 0, 0);
      chk("tout_still", 32'(tif.editing), 'h1);
      step(0, 0, 0, 0, 0, 0);
      chk("tout_ed", 32'(tif.editing), 'h0);
      chk("tout_wr", 32'(tif.wr_strobe), 'h0);
      chk("tout_hh", 32'(tif.hh_out), 'h06);

      // Tick on the timeout cycle wins
      step(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < TOUT - 1; i++) step(0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      chk("tout_tick_ed", 32'(tif.editing), 'h1);
      chk("tout_tick_hh", 32'(tif.hh_out), 'h06);
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Invalid load and reset during COMMIT
      set_time(8'h2A, 8'h60, 8'h45);
      step(0, 1, 0, 0, 0, 0);
      chk("inv_hh", 32'(tif.hh_out), 'h00);
      chk("inv_mm", 32'(tif.mm_out), 'h00);
      chk("inv_ss", 32'(tif.ss_out), 'h45);
      step(0, 1, 0, 0, 0, 0);
      chk("commit_wr", 32'(tif.wr_strobe), 'h1);
      step(1, 0, 0, 0, 0, 0);
      chk("rstc_wr", 32'(tif.wr_strobe), 'h0);
      chk("rstc_ss", 32'(tif.ss_out), 'h00);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         set_time(rand_field(HMAX), rand_field(59), rand_field(59));
         step($urandom_range(0, 199) == 0,
              $urandom_range(0, 11) == 0,
              $urandom_range(0, 4) == 0,
              $urandom_range(0, 4) == 0,
              $urandom_range(0, 5) == 0,
              $urandom_range(0, 5) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/edit_time_fields.md
EDIT_TIME_FIELDS -- requirements
Module: edit_time_fields

Interface
REQ-001 The block SHALL have one parameter: HOUR_MAX, default 23, the highest legal hour value (BCD 8'h23).
REQ-002 The block SHALL have one parameter: TIMEOUT_CYCLES, default 1000, the number of idle clkr cycles in EDIT before the block abandons editing.
REQ-003 clkr  input  1  system clock; all state updates on its rising edge.
REQ-004 resetr  input  1  synchronous, active-high reset.
REQ-005 tick_enter  input  1  single-cycle pulse from the enter button tick stage.
REQ-006 tick_up  input  1  single-cycle pulse; increment the selected field.
REQ-007 tick_down  input  1  single-cycle pulse; decrement the selected field.
REQ-008 tick_left  input  1  single-cycle pulse; move the cursor left.
REQ-009 tick_right  input  1  single-cycle pulse; move the cursor right.
REQ-010 hh_in, mm_in, ss_in  input  8 each  current RTC time, packed BCD.
REQ-011 hh_out, mm_out, ss_out  output  8 each  edited time, packed BCD.
REQ-012 cursor  output  2  selected field: 0 = hours, 1 = minutes, 2 = seconds.
REQ-013 editing  output  1  high while in state EDIT.
REQ-014 wr_strobe  output  1  one-cycle pulse that commits hh_out, mm_out and ss_out to the RTC.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, EDIT and COMMIT.
REQ-016 IDLE -> EDIT on tick_enter.
- Same edge: hh_in, mm_in and ss_in load into hh_out, mm_out and ss_out.
- Same edge: cursor loads 0 and the timeout counter clears.
REQ-017 On that load, any field with an invalid BCD digit, or a value above its maximum, SHALL load 8'h00.
- Maxima: HOUR_MAX for hours, 59 for minutes and seconds.
REQ-018 The block SHALL ignore tick_up, tick_down, tick_left and tick_right while in IDLE or COMMIT.
REQ-019 In EDIT, the block SHALL perform at most one action per cycle.
- Priority: enter > up > down > left > right.
- Lower-priority simultaneous ticks are discarded, not queued.
REQ-020 EDIT + tick_enter -> COMMIT.
- wr_strobe is high for exactly the single COMMIT cycle.
- Next cycle the FSM returns to IDLE.
- Total latency: wr_strobe asserts 1 cycle after the tick_enter edge.
REQ-021 tick_up SHALL BCD-increment the selected field.
- Ones digit 9 -> 0 with carry into the tens digit.
- Field at its maximum wraps to 8'h00.
- No carry propagates into any other field.
REQ-022 tick_down SHALL BCD-decrement the selected field.
- Ones digit 0 -> 9 with borrow from the tens digit.
- 8'h00 wraps to the field maximum.
- No borrow propagates into any other field.
REQ-023 tick_right SHALL advance the cursor 0 -> 1 -> 2 -> 0; tick_left SHALL retreat it 0 -> 2 -> 1 -> 0.
REQ-024 Cursor value 3 is unreachable; if it occurs, the cursor SHALL be forced to 0 on the next edge.
REQ-025 In EDIT, any tick SHALL clear the timeout counter; otherwise the counter increments by 1 per cycle.
REQ-026 When the timeout counter reaches TIMEOUT_CYCLES-1, EDIT -> IDLE with no wr_strobe.
- hh_out, mm_out and ss_out retain their edited values.
- A tick on that same cycle takes precedence: it is processed and the counter clears.
REQ-027 In IDLE, hh_out, mm_out, ss_out and cursor SHALL hold their values.
REQ-028 editing = 1 only in EDIT; wr_strobe = 1 only in COMMIT; both are registered outputs.

Reset
REQ-029 When resetr = 1 at a clkr edge, the block SHALL enter IDLE and drive:
- hh_out = mm_out = ss_out = 8'h00, cursor = 0;
- editing = 0, wr_strobe = 0, timeout counter = 0.
REQ-030 resetr SHALL take priority over every tick, including a reset asserted mid-EDIT or during the COMMIT cycle.
- In that case wr_strobe is not asserted, or is deasserted, on that edge.

Verification
REQ-031 Basic edit: hh_in=8'h09 -> enter, up -> hh_out=8'h10; enter -> wr_strobe high exactly 1 cycle, then IDLE.
REQ-032 Wrap: minutes = 8'h59 + up -> 8'h00; hours = 8'h00 + down -> 8'h23; seconds = 8'h00 + down -> 8'h59.
REQ-033 Cursor: from 0, left -> 2; then right x3 -> 2; tick_up and tick_left in the same cycle -> only the increment occurs.
REQ-034 Timeout: with TIMEOUT_CYCLES=8, enter then 8 idle cycles -> editing=0, no wr_strobe, edited values held.
REQ-035 Robustness:
- hh_in=8'h2A on enter -> hh_out=8'h00.
- resetr asserted in the COMMIT cycle -> wr_strobe low on that edge, all outputs 0.
